// File: rtl/cpu_pkg.sv
// Shared CPU constants: conditional-branch opcodes and the 2-bit predictor
// counter encoding used by the branch predictor table.
package cpu_pkg;

  localparam logic [5:0] OP_BLTZ = 6'h1;
  localparam logic [5:0] OP_BGEZ = 6'h1;
  localparam logic [5:0] OP_BEQ  = 6'h4;
  localparam logic [5:0] OP_BNE  = 6'h5;
  localparam logic [5:0] OP_BLEZ = 6'h6;
  localparam logic [5:0] OP_BGTZ = 6'h7;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // Decoder helper: true for every opcode the branch comparator resolves.
  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BLTZ) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor storage: two combinational read ports (IF lookup,
// ID update source), one synchronous write port, synchronous clear on reset.
module bp_table
  import cpu_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 30 - IDX_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] if_idx,
  output logic                if_valid,
  output logic [TAG_BITS-1:0] if_tag,
  output logic [31:0]         if_target,
  output logic [1:0]          if_ctr,
  input  logic [IDX_BITS-1:0] id_idx,
  output logic                id_valid,
  output logic [TAG_BITS-1:0] id_tag,
  output logic [31:0]         id_target,
  output logic [1:0]          id_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_valid,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_target,
  input  logic [1:0]          wr_ctr
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // Reads see pre-write contents, so a same-cycle lookup returns old data.
  assign if_valid  = valid_q[if_idx];
  assign if_tag    = tag_q[if_idx];
  assign if_target = target_q[if_idx];
  assign if_ctr    = ctr_q[if_idx];

  assign id_valid  = valid_q[id_idx];
  assign id_tag    = tag_q[id_idx];
  assign id_target = target_q[id_idx];
  assign id_ctr    = ctr_q[id_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with ID-stage misprediction recovery.
// Define BRANCH_PREDICT_EN to build the table; otherwise static predict-not-taken.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        stall,
  input  logic [31:0] id_pc,
  input  logic        id_is_branch,
  input  logic        id_taken,
  input  logic [31:0] id_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_ifid
);

`ifdef BRANCH_PREDICT_EN

  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [IDX_BITS-1:0] if_idx, id_idx;
  logic [TAG_BITS-1:0] if_tag, id_tag;

  logic                tbl_if_valid, tbl_id_valid;
  logic [TAG_BITS-1:0] tbl_if_tag, tbl_id_tag;
  logic [31:0]         tbl_if_target, tbl_id_target;
  logic [1:0]          tbl_if_ctr, tbl_id_ctr;

  logic                wr_en, wr_valid;
  logic [TAG_BITS-1:0] wr_tag;
  logic [31:0]         wr_target;
  logic [1:0]          wr_ctr;

  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        id_hit, mispredict, alias_hit;
  logic        unused_bits;

  function automatic logic [1:0] ctr_up(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_down(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign id_idx = id_pc[IDX_BITS+1:2];
  assign id_tag = id_pc[31:IDX_BITS+2];
  assign unused_bits = ^if_pc[1:0];

  bp_table #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) u_table (
    .clk      (clk),
    .reset    (reset),
    .if_idx   (if_idx),
    .if_valid (tbl_if_valid),
    .if_tag   (tbl_if_tag),
    .if_target(tbl_if_target),
    .if_ctr   (tbl_if_ctr),
    .id_idx   (id_idx),
    .id_valid (tbl_id_valid),
    .id_tag   (tbl_id_tag),
    .id_target(tbl_id_target),
    .id_ctr   (tbl_id_ctr),
    .wr_en    (wr_en),
    .wr_idx   (id_idx),
    .wr_valid (wr_valid),
    .wr_tag   (wr_tag),
    .wr_target(wr_target),
    .wr_ctr   (wr_ctr)
  );

  assign pred_taken  = tbl_if_valid & (tbl_if_tag == if_tag) & tbl_if_ctr[1];
  assign pred_target = pred_taken ? tbl_if_target : 32'd0;

  // Prediction travels with the instruction; a flush squashes it even mid-stall.
  always_ff @(posedge clk) begin
    if (reset || flush_ifid) begin
      id_pred_taken  <= 1'b0;
      id_pred_target <= 32'd0;
    end else if (!stall) begin
      id_pred_taken  <= pred_taken;
      id_pred_target <= pred_target;
    end
  end

  assign id_hit    = tbl_id_valid & (tbl_id_tag == id_tag);
  assign alias_hit = id_pred_taken & ~id_is_branch;

  always_comb begin
    mispredict = alias_hit
               | (id_is_branch & (id_taken != id_pred_taken))
               | (id_is_branch & id_taken & id_pred_taken & (id_target != id_pred_target));
    redirect    = mispredict;
    flush_ifid  = mispredict;
    redirect_pc = 32'd0;
    if (mispredict)
      redirect_pc = (id_taken & id_is_branch) ? id_target : id_pc + 32'd4;
  end

  // Table update: resolved branches train, non-branches that predicted taken are evicted.
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b1;
    wr_tag    = id_tag;
    wr_target = tbl_id_target;
    wr_ctr    = tbl_id_ctr;
    if (!stall) begin
      if (id_is_branch) begin
        if (id_hit) begin
          wr_en = 1'b1;
          if (id_taken) begin
            wr_ctr    = ctr_up(tbl_id_ctr);
            wr_target = id_target;
          end else begin
            wr_ctr = ctr_down(tbl_id_ctr);
          end
        end else if (id_taken) begin
          wr_en     = 1'b1;
          wr_target = id_target;
          wr_ctr    = CTR_WT;
        end
      end else if (id_pred_taken) begin
        wr_en    = 1'b1;
        wr_valid = 1'b0;
        wr_tag   = tbl_id_tag;
      end
    end
  end

`else

  logic [IDX_BITS-1:0] unused_idx;
  logic                unused_sig;

  assign unused_idx = if_pc[IDX_BITS+1:2];
  assign unused_sig = ^{clk, reset, stall, if_pc, id_pc};

  assign pred_taken  = 1'b0;
  assign pred_target = 32'd0;

  always_comb begin
    redirect    = id_is_branch & id_taken;
    flush_ifid  = redirect;
    redirect_pc = redirect ? id_target : 32'd0;
  end

`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor; expectations follow BRANCH_PREDICT_EN.
module tb_branch_predictor;

  typedef struct {
    int          step;
    logic        pt;
    logic [31:0] ptg;
    logic        rd;
    logic [31:0] rpc;
    logic        fl;
    bit          chk_rpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        stall;
  logic [31:0] id_pc;
  logic        id_is_branch;
  logic        id_taken;
  logic [31:0] id_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_ifid;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_pc       (if_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .stall       (stall),
    .id_pc       (id_pc),
    .id_is_branch(id_is_branch),
    .id_taken    (id_taken),
    .id_target   (id_target),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush_ifid  (flush_ifid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue its expected response.
  task automatic applyStimulus(input logic st, input logic [31:0] ipc,
                               input logic [31:0] dpc, input logic br,
                               input logic tk, input logic [31:0] tgt,
                               input logic e_pt, input logic [31:0] e_ptg,
                               input logic e_rd, input logic [31:0] e_rpc);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    stall        = st;
    if_pc        = ipc;
    id_pc        = dpc;
    id_is_branch = br;
    id_taken     = tk;
    id_target    = tgt;
    step++;
    e.step = step;
    e.pt   = e_pt;
    e.ptg  = e_ptg;
    e.rd   = e_rd;
    e.rpc  = e_rpc;
    e.fl   = e_rd;
`ifdef BRANCH_PREDICT_EN
    e.chk_rpc = 1'b1;
`else
    e.chk_rpc = e_rd;
`endif
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req, input int stp);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL step%0d %s actual=%h required=%h", stp, name, act, req);
    end
  endtask

  // Monitor: the DUT answers combinationally every cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, e.pt}, e.step);
        checkOutput("pred_target", pred_target, e.ptg, e.step);
        checkOutput("redirect", {31'd0, redirect}, {31'd0, e.rd}, e.step);
        checkOutput("flush_ifid", {31'd0, flush_ifid}, {31'd0, e.fl}, e.step);
        if (e.chk_rpc)
          checkOutput("redirect_pc", redirect_pc, e.rpc, e.step);
      end
    end
  end

  localparam logic [31:0] PA  = 32'h0040_0010;
  localparam logic [31:0] PA4 = 32'h0040_0014;
  localparam logic [31:0] PB  = 32'h0040_0050;
  localparam logic [31:0] PB4 = 32'h0040_0054;
  localparam logic [31:0] TA  = 32'h0040_0040;
  localparam logic [31:0] TB  = 32'h0040_0100;
  localparam logic [31:0] PC0 = 32'h0040_0080;

  initial begin
    reset = 1'b1; stall = 1'b0; if_pc = '0; id_pc = '0;
    id_is_branch = 1'b0; id_taken = 1'b0; id_target = '0;
    repeat (3) @(posedge clk);

    applyStimulus(0, 32'd0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
`ifdef BRANCH_PREDICT_EN
    // Cold miss, allocate, then predicted hit
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    applyStimulus(0, PA4, PA,    1, 1, TA,    0, 32'd0, 1, TA);
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 1, TA,    0, 32'd0);
    // Saturation: two more taken (10->11->11), then not-taken (11->10)
    applyStimulus(0, PA,  PA,    1, 1, TA,    1, TA,    0, 32'd0);
    applyStimulus(0, PA,  PA,    1, 1, TA,    1, TA,    0, 32'd0);
    applyStimulus(0, PA4, PA,    1, 0, TA,    0, 32'd0, 1, PA4);
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 1, TA,    0, 32'd0);
    // Predicted taken, resolved not-taken: 10->01
    applyStimulus(0, PA,  PA,    1, 0, TA,    1, TA,    1, PA4);
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    // Retrain 01->10, then replace with aliasing PC PB
    applyStimulus(0, PC0, PA,    1, 1, TA,    0, 32'd0, 1, TA);
    applyStimulus(0, PA,  PB,    1, 1, TB,    1, TA,    1, TB);
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    applyStimulus(0, PB,  32'd0, 0, 0, 32'd0, 1, TB,    0, 32'd0);
    // Alias: PB predicted taken but is not a branch
    applyStimulus(0, PA4, PB,    0, 0, 32'd0, 0, 32'd0, 1, PB4);
    applyStimulus(0, PB,  32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    // Build ctr=11 at PA with a not-taken ID prediction
    applyStimulus(0, PA4, PA,    1, 1, TA,    0, 32'd0, 1, TA);
    applyStimulus(0, PA4, PA,    1, 1, TA,    0, 32'd0, 1, TA);
    // Stall three cycles: no update, ID prediction held at 0
    applyStimulus(1, PA,  PA,    1, 0, TA,    1, TA,    0, 32'd0);
    applyStimulus(1, PA,  PA,    1, 0, TA,    1, TA,    0, 32'd0);
    applyStimulus(1, PA,  PA,    1, 0, TA,    1, TA,    0, 32'd0);
    applyStimulus(0, PA4, PA,    1, 0, TA,    0, 32'd0, 0, 32'd0);
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 1, TA,    0, 32'd0);
`else
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    applyStimulus(0, PA4, PA,    1, 1, TA,    0, 32'd0, 1, TA);
    applyStimulus(0, PA,  32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    applyStimulus(0, PA,  PA,    1, 0, TA,    0, 32'd0, 0, 32'd0);
    applyStimulus(0, PB,  PB,    0, 1, TB,    0, 32'd0, 0, 32'd0);
    applyStimulus(1, PB,  PB,    1, 1, TB,    0, 32'd0, 1, TB);
    applyStimulus(0, PA,  PB,    1, 0, TB,    0, 32'd0, 0, 32'd0);
    applyStimulus(0, PA,  PA,    1, 1, TA,    0, 32'd0, 1, TA);
`endif

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
